// File: rtl/spi_pkg.sv
// Shared SPI definitions: mode encoding, edge-role helpers, core FSM state and debug view.
package spi_pkg;
  localparam int SPI_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    SPI_MODE0 = 2'd0,
    SPI_MODE1 = 2'd1,
    SPI_MODE2 = 2'd2,
    SPI_MODE3 = 2'd3
  } spi_mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_e;

  typedef struct packed {
    spi_state_e state;
    logic [7:0] bit_cnt;
    logic       hold_full;
    logic       sclk_lvl;
    logic       cs_n_lvl;
  } spi_dbg_t;

  function automatic spi_mode_e spi_mode(input logic cpol, input logic cpha);
    return spi_mode_e'({cpol, cpha});
  endfunction

  // Modes 0 and 3 sample on the rising SCLK edge, modes 1 and 2 on the falling edge.
  function automatic logic is_sampling_edge(input spi_mode_e mode, input logic rise, input logic fall);
    return (mode == SPI_MODE0 || mode == SPI_MODE3) ? rise : fall;
  endfunction

  function automatic logic is_change_edge(input spi_mode_e mode, input logic rise, input logic fall);
    return (mode == SPI_MODE0 || mode == SPI_MODE3) ? fall : rise;
  endfunction
endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus a delayed copy for edge detection.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic meta, sync, dly;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      sync <= RESET_VAL;
      dly  <= RESET_VAL;
    end else begin
      meta <= din;
      sync <= meta;
      dly  <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~dly;
  assign fall  = ~sync & dly;
endmodule

// File: rtl/spi_slave_core.sv
// SPI responder: oversamples SCLK/CS_n/MOSI on clk, assembles rx words, shifts tx words out on MISO.
// Handshake: tx_data is captured on any clk edge where tx_valid && tx_ready; tx_ready is high while the holding register is empty.
module spi_slave_core
  import spi_pkg::*;
#(
  parameter logic CPOL       = 1'b0,
  parameter logic CPHA       = 1'b0,
  parameter int   DATA_WIDTH = SPI_DATA_WIDTH,
  parameter logic MSB_FIRST  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sclk,
  input  logic                  cs_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic                  miso_oe,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  tx_underrun,
  output logic                  frame_err,
  output spi_dbg_t              dbg
);
  localparam spi_mode_e       MODE     = spi_mode(CPOL, CPHA);
  localparam int              CW       = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]   LAST_BIT = CW'(DATA_WIDTH - 1);

  spi_state_e state, state_next;
  logic sclk_lvl, sclk_rise, sclk_fall;
  logic cs_lvl, cs_rise, cs_fall;
  logic mosi_meta, mosi_s;
  logic samp_edge, chg_edge;
  logic load, do_sample, do_shift, frame_end;
  logic [CW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_out, shift_in, shift_in_next, hold;
  logic                  hold_full, underrun_pend;

  spi_sync_edge #(.RESET_VAL(CPOL)) u_sclk_sync (
    .clk(clk), .reset(reset), .din(sclk), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_sync_edge #(.RESET_VAL(1'b1)) u_cs_sync (
    .clk(clk), .reset(reset), .din(cs_n), .level(cs_lvl), .rise(cs_rise), .fall(cs_fall)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mosi_meta <= 1'b0;
      mosi_s    <= 1'b0;
    end else begin
      mosi_meta <= mosi;
      mosi_s    <= mosi_meta;
    end
  end

  assign samp_edge     = is_sampling_edge(MODE, sclk_rise, sclk_fall);
  assign chg_edge      = is_change_edge(MODE, sclk_rise, sclk_fall);
  assign shift_in_next = MSB_FIRST ? {shift_in[DATA_WIDTH-2:0], mosi_s}
                                   : {mosi_s, shift_in[DATA_WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // A change edge only advances MISO once the current word has been sampled at least once;
  // this keeps the freshly reloaded word's first bit on the line in both CPHA settings.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    do_sample  = 1'b0;
    do_shift   = 1'b0;
    frame_end  = 1'b0;
    unique case (state)
      IDLE: begin
        if (cs_fall) begin
          state_next = ACTIVE;
          load       = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_next = IDLE;
          frame_end  = 1'b1;
        end else begin
          do_sample = samp_edge;
          do_shift  = chg_edge && (bit_cnt != '0);
          load      = samp_edge && (bit_cnt == LAST_BIT);
        end
      end
    endcase
  end

  // Underrun is reported when a word that was loaded empty actually starts shifting,
  // so the reload after a frame's final word never raises a spurious strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt       <= '0;
      shift_out     <= '0;
      shift_in      <= '0;
      hold          <= '0;
      hold_full     <= 1'b0;
      underrun_pend <= 1'b0;
      rx_data       <= '0;
      rx_valid      <= 1'b0;
      tx_underrun   <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      frame_err   <= 1'b0;
      if (load) begin
        if (hold_full) begin
          shift_out     <= hold;
          hold_full     <= 1'b0;
          underrun_pend <= 1'b0;
        end else if (tx_valid) begin
          shift_out     <= tx_data;
          underrun_pend <= 1'b0;
        end else begin
          shift_out     <= '0;
          underrun_pend <= 1'b1;
        end
      end else begin
        if (tx_valid && tx_ready) begin
          hold      <= tx_data;
          hold_full <= 1'b1;
        end
        if (do_shift) shift_out <= MSB_FIRST ? (shift_out << 1) : (shift_out >> 1);
      end
      if (do_sample) begin
        shift_in <= shift_in_next;
        if (bit_cnt == '0 && underrun_pend) begin
          tx_underrun   <= 1'b1;
          underrun_pend <= 1'b0;
        end
        if (bit_cnt == LAST_BIT) begin
          bit_cnt  <= '0;
          rx_data  <= shift_in_next;
          rx_valid <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (frame_end) begin
        frame_err     <= (bit_cnt != '0);
        bit_cnt       <= '0;
        underrun_pend <= 1'b0;
      end
    end
  end

  assign miso      = MSB_FIRST ? shift_out[DATA_WIDTH-1] : shift_out[0];
  assign miso_oe   = (state == ACTIVE);
  assign tx_ready  = ~hold_full;

  assign dbg.state     = state;
  assign dbg.bit_cnt   = 8'(bit_cnt);
  assign dbg.hold_full = hold_full;
  assign dbg.sclk_lvl  = sclk_lvl;
  assign dbg.cs_n_lvl  = cs_lvl;
endmodule

// File: tb/tb_spi_slave_core.sv
// Directed bench for spi_slave_core: all four modes MSB-first plus one LSB-first mode-0 instance.
module tb_spi_slave_core;
  import spi_pkg::*;

  localparam int N    = 5;
  localparam int HALF = 80;
  localparam logic [N-1:0] CPOL_V = 5'b01100;
  localparam logic [N-1:0] CPHA_V = 5'b01010;
  localparam logic [N-1:0] MSB_V  = 5'b01111;

  logic       clk = 1'b0;
  logic       reset;
  logic       mosi;
  logic       sclk [N];
  logic       cs_n [N];
  logic       miso [N];
  logic       miso_oe [N];
  logic [7:0] tx_data [N];
  logic       tx_valid [N];
  logic       tx_ready [N];
  logic [7:0] rx_data [N];
  logic       rx_valid [N];
  logic       tx_underrun [N];
  logic       frame_err [N];
  spi_dbg_t   dbg [N];

  int rx_cnt [N];
  int urun_cnt [N];
  int ferr_cnt [N];
  logic [7:0] exp_q[$];
  int cur = 0;
  int n_checks = 0;
  int n_fail = 0;

  // clock / reset
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    spi_slave_core #(
      .CPOL(CPOL_V[g]), .CPHA(CPHA_V[g]), .DATA_WIDTH(8), .MSB_FIRST(MSB_V[g])
    ) u_dut (
      .clk(clk), .reset(reset), .sclk(sclk[g]), .cs_n(cs_n[g]), .mosi(mosi),
      .miso(miso[g]), .miso_oe(miso_oe[g]), .tx_data(tx_data[g]), .tx_valid(tx_valid[g]),
      .tx_ready(tx_ready[g]), .rx_data(rx_data[g]), .rx_valid(rx_valid[g]),
      .tx_underrun(tx_underrun[g]), .frame_err(frame_err[g]), .dbg(dbg[g])
    );
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard + strobe counters
  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (rx_valid[g] === 1'b1)    rx_cnt[g]++;
      if (tx_underrun[g] === 1'b1) urun_cnt[g]++;
      if (frame_err[g] === 1'b1)   ferr_cnt[g]++;
    end
    if (rx_valid[cur] === 1'b1) begin
      if (exp_q.size() > 0) check_eq("rx_data", 32'(rx_data[cur]), 32'(exp_q.pop_front()));
      else                  check_eq("rx_unexpected_word", 32'(exp_q.size()), 32'd1);
    end
  end

  // driver tasks
  task automatic push_tx(input int d, input logic [7:0] val);
    logic ok;
    ok = 1'b0;
    @(negedge clk);
    tx_valid[d] = 1'b1;
    tx_data[d]  = val;
    for (int i = 0; i < 200; i++) begin
      if (tx_ready[d] === 1'b1) begin
        @(negedge clk);
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    tx_valid[d] = 1'b0;
    check_eq($sformatf("tx_accept_%0d", d), 32'(ok), 32'd1);
  endtask

  task automatic start_frame(input int d);
    cs_n[d] = 1'b0;
    #HALF;
    check_eq($sformatf("miso_oe_active_%0d", d), 32'(miso_oe[d]), 32'd1);
  endtask

  task automatic end_frame(input int d);
    #HALF;
    cs_n[d] = 1'b1;
    #(2 * HALF);
    check_eq($sformatf("miso_oe_idle_%0d", d), 32'(miso_oe[d]), 32'd0);
  endtask

  task automatic xfer(input int d, input int nbits, input logic [7:0] mw, output logic [7:0] sw);
    int b;
    sw = '0;
    for (int i = 0; i < nbits; i++) begin
      b = MSB_V[d] ? 7 - i : i;
      if (!CPHA_V[d]) begin
        mosi = mw[b];
        #HALF;
        sclk[d] = ~CPOL_V[d];
        sw[b]   = miso[d];
        #HALF;
        sclk[d] = CPOL_V[d];
      end else begin
        sclk[d] = ~CPOL_V[d];
        mosi    = mw[b];
        #HALF;
        sclk[d] = CPOL_V[d];
        sw[b]   = miso[d];
        #HALF;
      end
    end
  endtask

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL watchdog: got timeout expected test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    logic [7:0] sw;
    int r0, u0, f0;
    reset = 1'b1;
    mosi  = 1'b0;
    for (int g = 0; g < N; g++) begin
      sclk[g] = CPOL_V[g]; cs_n[g] = 1'b1; tx_valid[g] = 1'b0; tx_data[g] = '0;
    end
    repeat (4) @(negedge clk);
    check_eq("rst_miso", 32'(miso[0]), 32'd0);
    check_eq("rst_miso_oe", 32'(miso_oe[0]), 32'd0);
    check_eq("rst_tx_ready", 32'(tx_ready[0]), 32'd1);
    check_eq("rst_rx_data", 32'(rx_data[0]), 32'd0);
    check_eq("rst_rx_valid", 32'(rx_valid[0]), 32'd0);
    check_eq("rst_underrun", 32'(tx_underrun[0]), 32'd0);
    check_eq("rst_frame_err", 32'(frame_err[0]), 32'd0);
    check_eq("rst_state", 32'(dbg[0].state), 32'(IDLE));
    check_eq("rst_sclk_preset_m2", 32'(dbg[2].sclk_lvl), 32'd1);
    reset = 1'b0;
    repeat (3) @(negedge clk);

    // same word in every mode: tx 0xA5, master sends 0x3C
    for (int d = 0; d < 4; d++) begin
      cur = d; r0 = rx_cnt[d]; u0 = urun_cnt[d]; f0 = ferr_cnt[d];
      push_tx(d, 8'hA5);
      start_frame(d);
      exp_q.push_back(8'h3C);
      xfer(d, 8, 8'h3C, sw);
      end_frame(d);
      check_eq($sformatf("mode%0d_miso_word", d), 32'(sw), 32'hA5);
      check_eq($sformatf("mode%0d_rx_count", d), 32'(rx_cnt[d] - r0), 32'd1);
      check_eq($sformatf("mode%0d_underrun", d), 32'(urun_cnt[d] - u0), 32'd0);
      check_eq($sformatf("mode%0d_frame_err", d), 32'(ferr_cnt[d] - f0), 32'd0);
    end

    // SCLK toggling with CS_n high, then an empty frame: no activity
    cur = 0; r0 = rx_cnt[0]; u0 = urun_cnt[0]; f0 = ferr_cnt[0];
    for (int i = 0; i < 4; i++) begin
      sclk[0] = ~sclk[0];
      #HALF;
    end
    check_eq("cs_high_bit_cnt", 32'(dbg[0].bit_cnt), 32'd0);
    check_eq("cs_high_state", 32'(dbg[0].state), 32'(IDLE));
    cs_n[0] = 1'b0;
    #(2 * HALF);
    cs_n[0] = 1'b1;
    #(2 * HALF);
    check_eq("empty_rx", 32'(rx_cnt[0] - r0), 32'd0);
    check_eq("empty_underrun", 32'(urun_cnt[0] - u0), 32'd0);
    check_eq("empty_frame_err", 32'(ferr_cnt[0] - f0), 32'd0);

    // three words in one frame with only two tx words supplied
    r0 = rx_cnt[0]; u0 = urun_cnt[0];
    push_tx(0, 8'h11);
    start_frame(0);
    push_tx(0, 8'h22);
    check_eq("hold_full_ready", 32'(tx_ready[0]), 32'd0);
    exp_q.push_back(8'hC3); exp_q.push_back(8'h5A); exp_q.push_back(8'h96);
    xfer(0, 8, 8'hC3, sw);
    check_eq("burst_w0_miso", 32'(sw), 32'h11);
    xfer(0, 8, 8'h5A, sw);
    check_eq("burst_w1_miso", 32'(sw), 32'h22);
    xfer(0, 8, 8'h96, sw);
    check_eq("burst_w2_miso", 32'(sw), 32'h00);
    end_frame(0);
    check_eq("burst_rx_count", 32'(rx_cnt[0] - r0), 32'd3);
    check_eq("burst_underrun", 32'(urun_cnt[0] - u0), 32'd1);

    // partial word: 5 bits then CS_n rise
    r0 = rx_cnt[0]; f0 = ferr_cnt[0];
    push_tx(0, 8'h77);
    start_frame(0);
    xfer(0, 5, 8'hFF, sw);
    end_frame(0);
    check_eq("partial_miso", 32'(sw), 32'h70);
    check_eq("partial_rx_count", 32'(rx_cnt[0] - r0), 32'd0);
    check_eq("partial_frame_err_cycles", 32'(ferr_cnt[0] - f0), 32'd1);
    push_tx(0, 8'h9E);
    start_frame(0);
    exp_q.push_back(8'h42);
    xfer(0, 8, 8'h42, sw);
    end_frame(0);
    check_eq("after_partial_miso", 32'(sw), 32'h9E);
    check_eq("after_partial_rx_count", 32'(rx_cnt[0] - r0), 32'd1);

    // LSB-first instance
    cur = 4; r0 = rx_cnt[4];
    push_tx(4, 8'h35);
    start_frame(4);
    exp_q.push_back(8'h01);
    xfer(4, 8, 8'h01, sw);
    end_frame(4);
    check_eq("lsb_miso_word", 32'(sw), 32'h35);
    check_eq("lsb_rx_count", 32'(rx_cnt[4] - r0), 32'd1);

    // reset in the middle of a word with the holding register full
    cur = 0; r0 = rx_cnt[0];
    push_tx(0, 8'hF0);
    start_frame(0);
    push_tx(0, 8'h0F);
    xfer(0, 3, 8'hAA, sw);
    reset = 1'b1;
    #1;
    check_eq("midrst_miso_oe", 32'(miso_oe[0]), 32'd0);
    check_eq("midrst_tx_ready", 32'(tx_ready[0]), 32'd1);
    check_eq("midrst_miso", 32'(miso[0]), 32'd0);
    check_eq("midrst_bit_cnt", 32'(dbg[0].bit_cnt), 32'd0);
    @(negedge clk);
    cs_n[0] = 1'b1;
    sclk[0] = CPOL_V[0];
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("postrst_tx_ready", 32'(tx_ready[0]), 32'd1);
    check_eq("postrst_state", 32'(dbg[0].state), 32'(IDLE));
    push_tx(0, 8'hE7);
    start_frame(0);
    exp_q.push_back(8'h81);
    xfer(0, 8, 8'h81, sw);
    end_frame(0);
    check_eq("postrst_miso_word", 32'(sw), 32'hE7);
    check_eq("postrst_rx_count", 32'(rx_cnt[0] - r0), 32'd1);

    check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
